// File: rtl/spike_scheduler.sv
// spike_scheduler: two-queue priority event scheduler (external high-priority, internal low-priority) with FWFT head
module spike_scheduler #(
  parameter int N              = 256,
  parameter int M              = 8,
  parameter int EXT_DEPTH_LOG2 = 2,
  parameter int INT_DEPTH_LOG2 = 4
)(
  input  logic          CLK,
  input  logic          RST,
  input  logic          SPI_GATE_ACTIVITY_sync,
  input  logic          CTRL_SCHED_PUSH_EXT,
  input  logic [12:0]   CTRL_SCHED_EXT_DATA,
  input  logic          CTRL_SCHED_PUSH_INT,
  input  logic [M-1:0]  CTRL_SCHED_NEUR_ADDR,
  input  logic          CTRL_SCHED_POP_N,
  output logic [12:0]   SCHED_DATA_OUT,
  output logic          SCHED_SRC_EXT,
  output logic          SCHED_EMPTY,
  output logic          SCHED_FULL,
  output logic          SCHED_OVF
);
  localparam int ED = 1 << EXT_DEPTH_LOG2;
  localparam int ID = 1 << INT_DEPTH_LOG2;
  if (N > (1 << M)) begin : g_n_check
    $error("N does not fit in an M-bit neuron address");
  end
  logic                      rst_int;
  logic [12:0]               mem_ext [ED];
  logic [12:0]               mem_int [ID];
  logic [EXT_DEPTH_LOG2-1:0] rd_ext, wr_ext;
  logic [INT_DEPTH_LOG2-1:0] rd_int, wr_int;
  logic [EXT_DEPTH_LOG2:0]   cnt_ext;
  logic [INT_DEPTH_LOG2:0]   cnt_int;
  logic                      ext_empty, int_empty, ext_full, int_full;
  logic                      pop_ext, pop_int, push_ext, push_int;
  logic                      ovf;
  assign rst_int   = RST | SPI_GATE_ACTIVITY_sync;
  assign ext_empty = cnt_ext == '0;
  assign int_empty = cnt_int == '0;
  assign ext_full  = cnt_ext == (EXT_DEPTH_LOG2+1)'(ED);
  assign int_full  = cnt_int == (INT_DEPTH_LOG2+1)'(ID);
  // pop goes to whichever queue currently supplies the head; selection uses pre-edge counts
  assign pop_ext   = CTRL_SCHED_POP_N & ~ext_empty;
  assign pop_int   = CTRL_SCHED_POP_N & ext_empty & ~int_empty;
  // a full queue can still take a push when its head leaves on the same edge
  assign push_ext  = CTRL_SCHED_PUSH_EXT & (~ext_full | pop_ext);
  assign push_int  = CTRL_SCHED_PUSH_INT & (~int_full | pop_int);
  assign SCHED_DATA_OUT = !ext_empty ? mem_ext[rd_ext] : !int_empty ? mem_int[rd_int] : '0;
  assign SCHED_SRC_EXT  = ~ext_empty;
  assign SCHED_EMPTY    = ext_empty & int_empty;
  assign SCHED_FULL     = ext_full | int_full;
  assign SCHED_OVF      = ovf;
  // high-priority circular buffer holding external event words verbatim
  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      rd_ext  <= '0;
      wr_ext  <= '0;
      cnt_ext <= '0;
      for (int i = 0; i < ED; i++) mem_ext[i] <= '0;
    end else begin
      if (push_ext) begin
        mem_ext[wr_ext] <= CTRL_SCHED_EXT_DATA;
        wr_ext          <= wr_ext + EXT_DEPTH_LOG2'(1);
      end
      if (pop_ext) rd_ext <= rd_ext + EXT_DEPTH_LOG2'(1);
      cnt_ext <= cnt_ext + (EXT_DEPTH_LOG2+1)'(push_ext) - (EXT_DEPTH_LOG2+1)'(pop_ext);
    end
  end
  // low-priority circular buffer holding zero-extended neuron addresses
  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      rd_int  <= '0;
      wr_int  <= '0;
      cnt_int <= '0;
      for (int i = 0; i < ID; i++) mem_int[i] <= '0;
    end else begin
      if (push_int) begin
        mem_int[wr_int] <= {{(13-M){1'b0}}, CTRL_SCHED_NEUR_ADDR};
        wr_int          <= wr_int + INT_DEPTH_LOG2'(1);
      end
      if (pop_int) rd_int <= rd_int + INT_DEPTH_LOG2'(1);
      cnt_int <= cnt_int + (INT_DEPTH_LOG2+1)'(push_int) - (INT_DEPTH_LOG2+1)'(pop_int);
    end
  end
  // sticky overflow: any dropped push latches until reset
  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) ovf <= 1'b0;
    else if ((CTRL_SCHED_PUSH_EXT & ~push_ext) | (CTRL_SCHED_PUSH_INT & ~push_int)) ovf <= 1'b1;
  end
endmodule
